xbar_bridge_slave_adapter: RTL
==============================

Name: xbar_bridge_slave_adapter

Overview:
- One instance per XBAR bridge slave port, directly downstream of the bridge request arbitration.
- Accepts arbitrated requests carrying ID/AUX and forwards them to an L2 target port, with the address rebased to the target window.
- Stores ID/AUX of each outstanding transaction in an in-order FIFO.
- Re-attaches ID/AUX to target responses and drives data_r_valid/data_r_ID back to the bridge for back-routing.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- ID_WIDTH, 9, one-hot requester ID width
- AUX_WIDTH, 8, auxiliary sideband width
- MAX_OUTSTANDING, 4, FIFO depth; power of two, at least 2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- base_addr_i  in  ADDR_WIDTH  start address of this slave window (quasi-static)
- data_req_i  in  1  request from bridge
- data_add_i  in  ADDR_WIDTH  absolute address
- data_wen_i  in  1  0 = store, 1 = load
- data_wdata_i  in  DATA_WIDTH  write data
- data_be_i  in  BE_WIDTH  byte enables
- data_ID_i  in  ID_WIDTH  requester ID
- data_aux_i  in  AUX_WIDTH  request AUX
- data_gnt_o  out  1  grant to bridge
- data_r_valid_o  out  1  response valid
- data_r_rdata_o  out  DATA_WIDTH  response data
- data_r_ID_o  out  ID_WIDTH  response ID
- data_r_opc_o  out  1  response error
- data_r_aux_o  out  AUX_WIDTH  response AUX
- tgt_req_o  out  1  target request
- tgt_add_o  out  ADDR_WIDTH  rebased address
- tgt_wen_o  out  1  target type
- tgt_wdata_o  out  DATA_WIDTH  target write data
- tgt_be_o  out  BE_WIDTH  target byte enables
- tgt_gnt_i  in  1  target grant
- tgt_r_valid_i  in  1  target response; exactly one per granted request, loads and stores, in order
- tgt_r_rdata_i  in  DATA_WIDTH  target read data
- tgt_r_opc_i  in  1  target error
- err_o  out  1  sticky protocol error

Behaviour:
- Clock/reset: single clock, clk; reset rst is synchronous active-high.
- Reset effects: FIFO pointers and count cleared; err_o = 0; data_r_valid_o = 0; all registered response outputs = 0. Any outstanding metadata is discarded. The target must be reset in the same cycle.
- Request path (combinational, zero added latency):
  - tgt_req_o = data_req_i & ~full.
  - data_gnt_o = tgt_req_o & tgt_gnt_i.
  - tgt_wen_o, tgt_wdata_o, tgt_be_o pass through unchanged.
  - tgt_add_o = data_add_i - base_addr_i, modulo 2^ADDR_WIDTH (wraps, no saturation).
- full: registered count == MAX_OUTSTANDING. A pop in the same cycle does not release the grant; the freed slot is usable from the next cycle.
- Push: {data_ID_i, data_aux_i} is pushed on data_gnt_o.
- Pop: FIFO head is popped on tgt_r_valid_i.
- Simultaneous push and pop: count unchanged, both pointers advance, each wrapping modulo MAX_OUTSTANDING.
- Response, default build: same cycle as tgt_r_valid_i.
  - data_r_valid_o = tgt_r_valid_i & ~empty.
  - rdata/opc come from the target; ID/AUX come from the FIFO head.
- Response with empty FIFO: tgt_r_valid_i while empty is a protocol violation.
  - Response is suppressed (data_r_valid_o = 0) and no pop occurs.
  - err_o sets next cycle and holds until reset.
- While data_r_valid_o = 0: data_r_ID_o, data_r_aux_o, data_r_rdata_o, data_r_opc_o are don't-care.
- Backpressure: the bridge response path has no backpressure; responses are never stalled.
- Count width: clog2(MAX_OUTSTANDING)+1 bits.

Optional Feature:
- Macro: XBAR_BRIDGE_SLV_RESP_REG_EN.
- Defined: all data_r_* outputs are registered. Response latency is 1 cycle after tgt_r_valid_i. Pop still occurs in the tgt_r_valid_i cycle. Registered outputs reset to 0.
- Undefined: combinational response as described above.
- Request path and full semantics are identical in both builds.

Decomposition:
- Package xbar_bridge_pkg holds:
  - typedef struct packed xbar_meta_t {ID, aux} (package-level default widths ID 9, AUX 8); the adapter uses a local parameterised equivalent when its widths differ.
  - localparam XBAR_OPC_OK = 1'b0.
  - localparam XBAR_OPC_ERR = 1'b1.
- Sub-module xbar_bridge_meta_fifo: synchronous FIFO with push/pop/full/empty/head, depth MAX_OUTSTANDING, flop-based.

Test Plan:
- Rebase: base_addr_i=0x1000_0000, load to 0x1000_0040 with ID=0x004 AUX=0x5A; target returns 0xDEADBEEF after 3 cycles -> tgt_add_o=0x0000_0040; response rdata=0xDEADBEEF, ID=0x004, AUX=0x5A, opc=0.
- Ordering: 4 back-to-back stores with IDs 0x001, 0x002, 0x010, 0x100 and target gnt always 1 -> data_gnt_o high 4 cycles; responses return IDs in the same order.
- Full: 4 outstanding, no responses, 5th data_req_i=1 -> tgt_req_o=0, data_gnt_o=0. A response arrives and the 5th is requested in the same cycle -> grant only on the following cycle.
- Simultaneous push/pop at count 2 over 8 cycles, crossing pointer wrap -> count stays 2; ID sequence preserved.
- Empty violation: tgt_r_valid_i with no outstanding -> data_r_valid_o=0; err_o=1 next cycle; holds until rst=1.
- RESP_REG_EN build: repeat the rebase test -> response appears 1 cycle later than in the default build. Reset mid-burst with 2 outstanding -> all outputs 0, count 0, err_o 0.

Source files
------------

// File: rtl/xbar_bridge_pkg.sv
//------------------------------------------------------------------------------
// Module   : xbar_bridge_pkg
// Brief    : Shared types and constants for the XBAR bridge slave adapter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package xbar_bridge_pkg;

    localparam int XBAR_ID_WIDTH  = 9;
    localparam int XBAR_AUX_WIDTH = 8;

    typedef struct packed {
        logic [XBAR_ID_WIDTH-1:0]  id;
        logic [XBAR_AUX_WIDTH-1:0] aux;
    } xbar_meta_t;

    localparam logic XBAR_OPC_OK  = 1'b0;
    localparam logic XBAR_OPC_ERR = 1'b1;

endpackage

`default_nettype wire

// File: rtl/xbar_bridge_meta_fifo.sv
//------------------------------------------------------------------------------
// Module   : xbar_bridge_meta_fifo
// Brief    : Flop-based in-order FIFO holding metadata of outstanding requests.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xbar_bridge_meta_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wdata;
    end

endmodule

`default_nettype wire

// File: rtl/xbar_bridge_slave_adapter.sv
//------------------------------------------------------------------------------
// Module   : xbar_bridge_slave_adapter
// Brief    : Forwards bridge requests to an L2 target with a rebased address and
//            re-attaches ID/AUX to in-order target responses.
//            Define XBAR_BRIDGE_SLV_RESP_REG_EN to register the response outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xbar_bridge_slave_adapter
    import xbar_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int ID_WIDTH        = 9,
    parameter int AUX_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_add_i,
    input  logic                  data_wen_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    input  logic [BE_WIDTH-1:0]   data_be_i,
    input  logic [ID_WIDTH-1:0]   data_ID_i,
    input  logic [AUX_WIDTH-1:0]  data_aux_i,
    output logic                  data_gnt_o,
    output logic                  data_r_valid_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic [ID_WIDTH-1:0]   data_r_ID_o,
    output logic                  data_r_opc_o,
    output logic [AUX_WIDTH-1:0]  data_r_aux_o,
    output logic                  tgt_req_o,
    output logic [ADDR_WIDTH-1:0] tgt_add_o,
    output logic                  tgt_wen_o,
    output logic [DATA_WIDTH-1:0] tgt_wdata_o,
    output logic [BE_WIDTH-1:0]   tgt_be_o,
    input  logic                  tgt_gnt_i,
    input  logic                  tgt_r_valid_i,
    input  logic [DATA_WIDTH-1:0] tgt_r_rdata_i,
    input  logic                  tgt_r_opc_i,
    output logic                  err_o
);

    typedef struct packed {
        logic [ID_WIDTH-1:0]  id;
        logic [AUX_WIDTH-1:0] aux;
    } meta_t;

    meta_t w_meta_in;
    meta_t w_meta_head;
    logic  w_full;
    logic  w_empty;
    logic  w_rsp_valid;
    logic  w_rsp_opc;
    logic  r_err;

    assign tgt_req_o   = data_req_i & ~w_full;
    assign data_gnt_o  = tgt_req_o & tgt_gnt_i;
    assign tgt_add_o   = data_add_i - base_addr_i;
    assign tgt_wen_o   = data_wen_i;
    assign tgt_wdata_o = data_wdata_i;
    assign tgt_be_o    = data_be_i;

    assign w_meta_in.id  = data_ID_i;
    assign w_meta_in.aux = data_aux_i;

    xbar_bridge_meta_fifo #(
        .WIDTH (ID_WIDTH + AUX_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_meta_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_gnt_o),
        .pop   (tgt_r_valid_i),
        .wdata (w_meta_in),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_meta_head)
    );

    // A response with nothing outstanding is dropped and flagged.
    assign w_rsp_valid = tgt_r_valid_i & ~w_empty;
    assign w_rsp_opc   = (w_rsp_valid && (tgt_r_opc_i == XBAR_OPC_ERR)) ? XBAR_OPC_ERR : XBAR_OPC_OK;

    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= r_err | (tgt_r_valid_i & w_empty);
    end
    assign err_o = r_err;

`ifdef XBAR_BRIDGE_SLV_RESP_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r_valid_o <= 1'b0;
            data_r_rdata_o <= '0;
            data_r_ID_o    <= '0;
            data_r_opc_o   <= XBAR_OPC_OK;
            data_r_aux_o   <= '0;
        end else begin
            data_r_valid_o <= w_rsp_valid;
            data_r_rdata_o <= tgt_r_rdata_i;
            data_r_ID_o    <= w_meta_head.id;
            data_r_opc_o   <= w_rsp_opc;
            data_r_aux_o   <= w_meta_head.aux;
        end
    end
`else
    assign data_r_valid_o = w_rsp_valid;
    assign data_r_rdata_o = tgt_r_rdata_i;
    assign data_r_ID_o    = w_meta_head.id;
    assign data_r_opc_o   = w_rsp_opc;
    assign data_r_aux_o   = w_meta_head.aux;
`endif

endmodule

`default_nettype wire
